// File: rtl/if_id_buffer_pkg.sv
// Shared definitions for the IF/ID receive buffer: default widths, the decode
// NOP encoding and the pointer-width helper.
package if_id_buffer_pkg;

    localparam int WIDTH_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR = 32'hE1A00000;

    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) bits++;
        return bits;
    endfunction

endpackage

// File: rtl/if_id_fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, asynchronous read.
module if_id_fifo_mem #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_buffer.sv
// Decode-side instruction FIFO: captures fetch output, presents the head to ID,
// raises freeze one entry before full and drops everything on a taken branch.
module if_id_buffer
    import if_id_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_valid,
    input  logic [WIDTH-1:0]        if_instruction,
    input  logic [WIDTH-1:0]        if_pc,
    input  logic                    branch_taken,
    input  logic                    id_stall,
    output logic                    freeze,
    output logic                    id_valid,
    output logic [WIDTH-1:0]        id_instruction,
    output logic [WIDTH-1:0]        id_pc,
    output logic [clog2(DEPTH):0]   count
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] FREEZE_CNT = CW'(DEPTH - 1);

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count_next;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;

    assign id_valid = (count != '0);
    assign push     = if_valid & ~branch_taken & (count < FULL_CNT);
    assign pop      = id_valid & ~id_stall & ~branch_taken;

    always_comb begin
        count_next = count;
        if (branch_taken) begin
            count_next = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_next = count + CW'(1);
                2'b01:   count_next = count - CW'(1);
                default: count_next = count;
            endcase
        end
    end

    // freeze is registered from the next-state count so fetch sees it on the
    // same edge the occupancy lands; the spare entry absorbs the late arrival.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            freeze <= 1'b0;
        end else begin
            count  <= count_next;
            freeze <= (count_next >= FREEZE_CNT);
            if (branch_taken) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    if_id_fifo_mem #(
        .DEPTH (DEPTH),
        .DATA_W(2 * WIDTH),
        .ADDR_W(AW)
    ) u_mem (
        .clk  (clk),
        .we   (push),
        .waddr(wr_ptr),
        .wdata({if_pc, if_instruction}),
        .raddr(rd_ptr),
        .rdata(head)
    );

    assign id_instruction = id_valid ? head[WIDTH-1:0]       : '0;
    assign id_pc          = id_valid ? head[2*WIDTH-1:WIDTH] : '0;

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(if_valid && !branch_taken && count == FULL_CNT));

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, streaming, backpressure, flush,
// pointer wrap and stall-while-empty.
module tb_if_id_buffer;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc;
    logic        branch_taken;
    logic        id_stall;
    logic        freeze;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;

    if_id_buffer #(.DEPTH(4), .WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_valid      (if_valid),
        .if_instruction(if_instruction),
        .if_pc         (if_pc),
        .branch_taken  (branch_taken),
        .id_stall      (id_stall),
        .freeze        (freeze),
        .id_valid      (id_valid),
        .id_instruction(id_instruction),
        .id_pc         (id_pc),
        .count         (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] q[$];
    logic [63:0] head;
    int          pushed;
    int          cyc;
    logic        do_push;
    logic        do_pop;

    initial begin
        rst = 1'b1;
        if_valid = 1'b0;
        if_instruction = '0;
        if_pc = '0;
        branch_taken = 1'b0;
        id_stall = 1'b0;
        #12;
        rst = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(id_valid), 32'd0);
        chk("reset_freeze", 32'(freeze), 32'd0);
        chk("reset_instr", id_instruction, 32'd0);

        // stall with empty buffer
        id_stall = 1'b1;
        step();
        step();
        chk("empty_stall_valid", 32'(id_valid), 32'd0);
        chk("empty_stall_count", 32'(count), 32'd0);
        chk("empty_stall_pc", id_pc, 32'd0);
        chk("empty_stall_instr", id_instruction, 32'd0);

        // streaming: each instruction visible one cycle after arrival
        id_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if_valid = 1'b1;
            if_pc = 32'(4 * i);
            if_instruction = 32'hE3A01000 + 32'(i);
            step();
            chk("stream_pc", id_pc, 32'(4 * i));
            chk("stream_instr", id_instruction, 32'hE3A01000 + 32'(i));
            chk("stream_count", 32'(count), 32'd1);
            chk("stream_freeze", 32'(freeze), 32'd0);
        end
        if_valid = 1'b0;
        step();
        chk("stream_drain_count", 32'(count), 32'd0);

        // backpressure: stall and keep pushing
        id_stall = 1'b1;
        if_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if_pc = 32'h40 + 32'(4 * i);
            if_instruction = 32'hE3A02000 + 32'(i);
            step();
            chk("bp_fill_count", 32'(count), 32'(i + 1));
            chk("bp_fill_freeze", 32'(freeze), (i >= 2) ? 32'd1 : 32'd0);
            chk("bp_fill_head", id_pc, 32'h40);
        end
        if_valid = 1'b0;
        id_stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("bp_drain_count", 32'(count), 32'(4 - i));
            chk("bp_drain_freeze", 32'(freeze), (i == 1) ? 32'd1 : 32'd0);
            if (i < 4) begin
                chk("bp_drain_pc", id_pc, 32'h40 + 32'(4 * i));
                chk("bp_drain_instr", id_instruction, 32'hE3A02000 + 32'(i));
            end else begin
                chk("bp_drain_valid", 32'(id_valid), 32'd0);
            end
        end

        // flush with wrong-path instruction presented in the same cycle
        id_stall = 1'b1;
        if_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_pc = 32'h60 + 32'(4 * i);
            if_instruction = 32'hE3A03000 + 32'(i);
            step();
        end
        chk("flush_pre_count", 32'(count), 32'd3);
        chk("flush_pre_freeze", 32'(freeze), 32'd1);
        if_pc = 32'h20;
        if_instruction = 32'hDEADBEEF;
        branch_taken = 1'b1;
        step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(id_valid), 32'd0);
        chk("flush_freeze", 32'(freeze), 32'd0);
        chk("flush_pc", id_pc, 32'd0);
        branch_taken = 1'b0;
        id_stall = 1'b0;
        if_pc = 32'h100;
        if_instruction = 32'hE3A04000;
        step();
        chk("post_flush_pc", id_pc, 32'h100);
        chk("post_flush_count", 32'(count), 32'd1);
        if_valid = 1'b0;
        step();
        chk("post_flush_drain", 32'(id_valid), 32'd0);
        chk("post_flush_drain_pc", id_pc, 32'd0);

        // wrap-around with alternating stalls, checked against a queue
        pushed = 0;
        cyc = 0;
        while ((pushed < 10 || q.size() != 0) && cyc < 80) begin
            id_stall = cyc[0];
            do_push = (pushed < 10) && (q.size() < 4);
            do_pop  = (q.size() != 0) && !id_stall;
            if_valid = do_push;
            if_pc = 32'h200 + 32'(4 * pushed);
            if_instruction = 32'hE3A05000 + 32'(pushed);
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back({if_pc, if_instruction});
                pushed++;
            end
            step();
            cyc++;
            chk("wrap_count", 32'(count), 32'(q.size()));
            if (q.size() != 0) begin
                head = q[0];
                chk("wrap_pc", id_pc, head[63:32]);
                chk("wrap_instr", id_instruction, head[31:0]);
            end else begin
                chk("wrap_empty_valid", 32'(id_valid), 32'd0);
            end
        end
        chk("wrap_timeout", 32'(cyc < 80), 32'd1);
        if_valid = 1'b0;
        id_stall = 1'b0;

        // asynchronous reset mid-cycle with two entries held
        id_stall = 1'b1;
        if_valid = 1'b1;
        step();
        step();
        if_valid = 1'b0;
        chk("async_pre_count", 32'(count), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_valid", 32'(id_valid), 32'd0);
        chk("async_freeze", 32'(freeze), 32'd0);
        chk("async_instr", id_instruction, 32'd0);
        #3;
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- Decode-side receiver for the instruction-fetch interface.
- Captures the fetched instruction and its pc from the fetch stage into a small FIFO and presents them to the ID stage with a valid flag.
- Drives freeze back to fetch as backpressure when the FIFO nears full.
- Flushes all wrong-path entries when a branch is taken.
- Sits between the fetch stage and ID in the ARM pipeline top.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- WIDTH, 32, instruction and pc width.

Ports:
- clk  input  1  pipeline clock.
- rst  input  1  asynchronous active-high reset.
- if_valid  input  1  fetch output holds a new instruction this cycle; top drives it with ~freeze.
- if_instruction  input  WIDTH  instruction from the fetch stage.
- if_pc  input  WIDTH  pc from the fetch stage (pc+4 value).
- branch_taken  input  1  branch resolved taken this cycle; same signal sent to fetch.
- id_stall  input  1  ID cannot consume this cycle (hazard unit).
- freeze  output  1  backpressure to the fetch stage; holds the fetch PC.
- id_valid  output  1  head entry is valid for ID.
- id_instruction  output  WIDTH  head instruction.
- id_pc  output  WIDTH  head pc.
- count  output  log2(DEPTH)+1  occupancy, for debug.

Behaviour:
- Reset is asynchronous, active-high. On reset: rd_ptr=wr_ptr=0, count=0, id_valid=0, freeze=0, storage contents don't-care.
- Outputs id_instruction and id_pc come from the head entry.
  - They are combinational from registered storage.
  - They are forced to 0 when id_valid=0.
- id_valid = (count != 0).
- Push: if_valid & ~branch_taken & (count < DEPTH). The push writes at wr_ptr on the clk edge, then wr_ptr increments and wraps modulo DEPTH.
- Pop: id_valid & ~id_stall & ~branch_taken. rd_ptr increments and wraps modulo DEPTH.
- Simultaneous push and pop leaves count unchanged, and the data passes through correctly. When count==1, the popped entry is the old head and the new entry becomes the head next cycle.
- Latency: an instruction presented by fetch in cycle N appears at the ID outputs in cycle N+1 when the buffer was empty. There is no bypass path.
- freeze = (count >= DEPTH-1), registered from next-state count.
  - Fetch responds one edge late, so one instruction can still arrive while freeze is asserted.
  - The headroom entry guarantees that arrival is never dropped.
- Overflow (push while count==DEPTH) must not occur by construction.
  - The write is suppressed.
  - A simulation-only assertion flags it.
- Flush: branch_taken=1 at an edge sets rd_ptr=wr_ptr=0 and count=0.
  - The concurrent if_valid input is discarded, because the fetch output in the flush cycle is wrong-path.
  - id_valid=0 in the cycle after the flush.
  - freeze deasserts in the cycle after the flush.
  - The first correct-path instruction is accepted in the following cycle.
- Flush has priority over push, pop and stall.
- id_stall with an empty buffer has no effect.
- Reset mid-operation clears the buffer immediately (asynchronous), independent of clk.

Decomposition:
- Shared package holds WIDTH default 32, the NOP encoding 32'hE1A00000 (used by ID when id_valid=0), and the pointer-width function clog2.
- One natural sub-module: if_id_fifo_mem, a DEPTH x 2*WIDTH register array with one write port and an asynchronous read port, no reset.
- Pointer, count, freeze and flush control stay in if_id_buffer.

Test Plan:
- Reset: assert rst mid-cycle with count=2 → count=0, id_valid=0, freeze=0 immediately, without a clk edge.
- Streaming: id_stall=0, if_valid every cycle with pc 4,8,12,16 and instructions 0xE3A01001..0xE3A01004 → ID sees the same sequence one cycle later, count stays at 1, freeze never asserts.
- Backpressure: id_stall=1 with a continuous push → freeze rises when count reaches 3. One more in-flight instruction lands (count=4) and no entry is lost. Releasing the stall drains entries in order, and freeze falls once count<3.
- Flush: count=3, branch_taken=1 with if_valid=1 and if_pc=0x20 → next cycle count=0 and id_valid=0, and the pc 0x20 entry never appears. The next if_pc=0x100 appears at ID one cycle after arrival.
- Wrap-around: push and pop 10 instructions through DEPTH=4 with alternating stalls → ordering is preserved across pointer wrap, and count never exceeds 4.
- Stall while empty: id_stall=1, if_valid=0 → id_valid stays 0, outputs stay 0, count stays 0.
